// File: rtl/seq_muldiv_unit.sv
// rtl/seq_muldiv_unit.sv - multi-cycle radix-4 Booth multiplier / restoring divider with start/done handshake
// Optional divider enabled by defining MULDIV_DIV_EN; without it, divide ops finish in FIXUP with err=1.

module seq_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             err
);

    localparam int EXT      = WIDTH + 2;
    localparam int MUL_ITER = WIDTH / 2 + 1;
    localparam int CW       = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div_q;

    // Booth datapath: {acc, mplr} shifts right two bits per step, so after
    // MUL_ITER steps it holds the full signed product of the extended operands.
    logic [EXT+1:0]   acc;
    logic [EXT+1:0]   mcand;
    logic [EXT-1:0]   mplr;
    logic             qm1;
    logic [EXT+1:0]   booth_add;
    logic [EXT+1:0]   booth_sum;
    logic [2*EXT+1:0] booth_shift;

    always_comb begin
        booth_add = '0;
        case ({mplr[1:0], qm1})
            3'b001, 3'b010: booth_add = mcand;
            3'b011:         booth_add = mcand << 1;
            3'b100:         booth_add = -(mcand << 1);
            3'b101, 3'b110: booth_add = -mcand;
            default:        booth_add = '0;
        endcase
        booth_sum   = acc + booth_add;
        booth_shift = $unsigned($signed({booth_sum, mplr}) >>> 2);
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial_r;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitude of MIN wraps to itself, which reads correctly as unsigned.
    always_comb begin
        a_mag   = (!op[0] && a[WIDTH-1]) ? -a : a;
        b_mag   = (!op[0] && b[WIDTH-1]) ? -b : b;
        trial_r = {rem, quo[WIDTH-1]};
        trial_d = trial_r - {1'b0, dvsr};
        quo_fix = neg_q ? -quo : quo;
        rem_fix = neg_r ? -rem : rem;
    end
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div_q <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            qm1      <= 1'b0;
`ifdef MULDIV_DIV_EN
            a_q      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        acc      <= '0;
                        qm1      <= 1'b0;
                        mcand    <= op[0] ? {4'b0, a} : {{4{a[WIDTH-1]}}, a};
                        mplr     <= op[0] ? {2'b0, b} : {{2{b[WIDTH-1]}}, b};
                        if (op[1]) begin
`ifdef MULDIV_DIV_EN
                            a_q      <= a;
                            rem      <= '0;
                            quo      <= a_mag;
                            dvsr     <= b_mag;
                            neg_r    <= !op[0] && a[WIDTH-1];
                            neg_q    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                            div_zero <= (b == '0);
                            cnt      <= CW'(WIDTH - 1);
                            state    <= (b == '0) ? S_FIXUP : S_RUN;
`else
                            state    <= S_FIXUP;
`endif
                        end else begin
                            cnt   <= CW'(MUL_ITER - 1);
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Both datapaths step; only the one selected by is_div_q is read in FIXUP.
                    acc  <= booth_shift[2*EXT+1:EXT];
                    mplr <= booth_shift[EXT-1:0];
                    qm1  <= mplr[1];
`ifdef MULDIV_DIV_EN
                    if (!trial_d[WIDTH]) begin
                        rem <= trial_d[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= trial_r[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
`endif
                    if (cnt == '0) begin
                        state <= S_FIXUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIXUP: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div_q) begin
`ifdef MULDIV_DIV_EN
                        if (div_zero) begin
                            hi  <= a_q;
                            lo  <= '1;
                            err <= 1'b1;
                        end else begin
                            hi  <= rem_fix;
                            lo  <= quo_fix;
                            err <= 1'b0;
                        end
`else
                        hi  <= '0;
                        lo  <= '0;
                        err <= 1'b1;
`endif
                    end else begin
                        hi  <= {acc[WIDTH-3:0], mplr[WIDTH+1:WIDTH]};
                        lo  <= mplr[WIDTH-1:0];
                        err <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb/tb_seq_muldiv_unit.sv - directed self-checking bench for seq_muldiv_unit (WIDTH=32)

module tb_seq_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;

    int checks = 0;
    int errors = 0;

    seq_muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .err(err)
    );

    always #5 clock = ~clock;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Latency is the edge index (accept = 0) at which a consumer samples done=1.
    task automatic wait_done(input int poke_at, output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            start = (k == poke_at);
            if (k == poke_at) begin
                op = 2'b01;
                a  = 32'h0000_1111;
                b  = 32'h0000_2222;
            end
            @(posedge clock);
            #1;
            if (done) begin
                lat = k + 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ee, input int elat, input int poke_at);
        int lat;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0; op = ~o; a = ~x; b = y + 32'd3;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_done(poke_at, lat);
        chk({tag, "_lat"}, W'(lat), W'(elat));
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, ee});
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_hold"}, lo, el);
    endtask

    initial begin
        int lat;
        int seen;
        clear = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b1; a = 32'd5; b = 32'd6;
        @(posedge clock);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        start = 1'b0; clear = 1'b0;

        run_op("mul_small", 2'b00, 32'h0000_00CB, 32'h0000_00C2, 32'h0, 32'h0000_99D6, 1'b0, 19, 0);
        run_op("mul_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 19, 0);
        run_op("mulu_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 19, 0);
        run_op("mulu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 19, 0);
        run_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 19, 0);
        run_op("mul_poke", 2'b00, 32'h0000_00CB, 32'h0000_00C2, 32'h0, 32'h0000_99D6, 1'b0, 19, 5);

        if (DIV_ON) begin
            run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0);
            run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 0);
            run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, 0);
            run_op("div_minm1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 0);
            run_op("div_zero", 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2, 0);
        end else begin
            run_op("div_off", 2'b10, 32'd100, 32'd0, 32'h0, 32'h0, 1'b1, 2, 0);
            run_op("divu_off", 2'b11, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, 2, 0);
        end
        run_op("mul_after", 2'b00, 32'd3, 32'd7, 32'h0, 32'd21, 1'b0, 19, 0);

        // Abort: clear at edge 10 of a multiply, start pulse at edge 5 in between.
        @(negedge clock);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 5);
            clear = (k == 10);
            @(posedge clock);
            #1;
        end
        start = 1'b0; clear = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            #1;
            if (done) seen++;
        end
        chk("abort_nodone", W'(seen), 32'd0);
        run_op("mul_restart", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 19, 0);

        // Back-to-back: second start accepted in the DONE cycle of the first.
        @(negedge clock);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd1000;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(0, lat);
        chk("b2b_lat1", W'(lat), 32'd19);
        chk("b2b_lo1", lo, 32'd1000000);
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd2;
        @(posedge clock);
        #1;
        start = 1'b0; a = '0; b = '0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_done_low", {31'b0, done}, 32'd0);
        chk("b2b_hold", lo, 32'd1000000);
        wait_done(0, lat);
        chk("b2b_lat2", W'(lat), 32'd19);
        chk("b2b_hi2", hi, 32'hFFFF_FFFF);
        chk("b2b_lo2", lo, 32'hFFFF_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
